// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a req/ack instruction memory and
// keeps one skid entry for a word returned under freeze. Optional: FETCH_PERF_CNT_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        br_taken,
  input  logic [31:0] id_pc,
  input  logic [31:0] br_offset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        inst_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic        if_flush
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] skid_inst_r;
  logic [31:0] skid_pc_r;
  logic        redirect_s;
  logic [31:0] target_s;
  logic [31:0] pc_inc_s;
  logic [31:0] pc_sel_s;

  function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                input logic [31:0] offset);
    return base + {offset[29:0], 2'b00};
  endfunction

  // freeze always beats a taken branch
  assign redirect_s = br_taken & ~freeze;
  assign if_flush   = redirect_s;
  assign target_s   = branch_target(id_pc, br_offset);
  assign pc_inc_s   = pc_r + PC_INC;
  assign pc_sel_s   = redirect_s ? target_s : pc_r;

  // Fetch state machine with registered memory-port and IF/ID outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instruction <= 32'h0000_0000;
      pc_out      <= 32'h0000_0000;
      inst_valid  <= 1'b0;
      skid_inst_r <= 32'h0000_0000;
      skid_pc_r   <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          state_r   <= REQ;
          imem_req  <= 1'b1;
          imem_addr <= pc_r;
        end
        REQ: begin
          if (imem_ack) begin
            if (redirect_s) begin
              pc_r       <= target_s;
              imem_addr  <= target_s;
              inst_valid <= 1'b0;
            end else if (freeze) begin
              skid_inst_r <= imem_rdata;
              skid_pc_r   <= pc_inc_s;
              pc_r        <= pc_inc_s;
              imem_addr   <= pc_inc_s;
              imem_req    <= 1'b0;
              state_r     <= HOLD;
            end else begin
              instruction <= imem_rdata;
              pc_out      <= pc_inc_s;
              inst_valid  <= 1'b1;
              pc_r        <= pc_inc_s;
              imem_addr   <= pc_inc_s;
            end
          end else begin
            // address must stay put until the memory acks
            if (redirect_s) begin
              pc_r       <= target_s;
              inst_valid <= 1'b0;
              state_r    <= DRAIN;
            end else if (!freeze) begin
              inst_valid <= 1'b0;
            end else begin
              inst_valid <= inst_valid;
            end
          end
        end
        DRAIN: begin
          pc_r <= pc_sel_s;
          if (!freeze) begin
            inst_valid <= 1'b0;
          end else begin
            inst_valid <= inst_valid;
          end
          if (imem_ack) begin
            imem_addr <= pc_sel_s;
            state_r   <= REQ;
          end else begin
            imem_addr <= imem_addr;
          end
        end
        HOLD: begin
          if (redirect_s) begin
            pc_r        <= target_s;
            imem_addr   <= target_s;
            imem_req    <= 1'b1;
            inst_valid  <= 1'b0;
            skid_inst_r <= 32'h0000_0000;
            skid_pc_r   <= 32'h0000_0000;
            state_r     <= REQ;
          end else if (!freeze) begin
            instruction <= skid_inst_r;
            pc_out      <= skid_pc_r;
            inst_valid  <= 1'b1;
            imem_addr   <= pc_r;
            imem_req    <= 1'b1;
            state_r     <= REQ;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r  <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall_s;
  assign stall_s = freeze | ((state_r == REQ) & ~imem_ack);

  // Free-running wrap-around performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= 32'h0000_0000;
      perf_flush_cnt <= 32'h0000_0000;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + {31'h0, stall_s};
      perf_flush_cnt <= perf_flush_cnt + {31'h0, redirect_s};
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a per-cycle vector table plus hand-written
// sequences for reset mid-request and a two-cycle memory latency.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] id_pc = 32'h0;
  logic [31:0] br_offset = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic        if_flush;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // memory model: word = address, ack after `lat` wait cycles unless stalled
  logic mem_stall = 1'b0;
  int   lat = 0;
  int   wait_cnt = 0;
  assign imem_ack   = imem_req && !mem_stall && (wait_cnt >= lat);
  assign imem_rdata = imem_addr;

  always @(posedge clk) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken),
    .id_pc(id_pc), .br_offset(br_offset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instruction(instruction), .pc_out(pc_out), .inst_valid(inst_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .if_flush(if_flush)
  );

  typedef struct {
    logic        frz;
    logic        br;
    logic [31:0] idpc;
    logic [31:0] off;
    logic        stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_flush;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    // frz br idpc off stall | req addr valid inst pc flush
    vecs[0]  = '{1'b0,1'b0,32'h00,32'h0,1'b0, 1'b1,32'h00,1'b0,32'h00,32'h00,1'b0};
    vecs[1]  = '{1'b0,1'b0,32'h00,32'h0,1'b0, 1'b1,32'h04,1'b1,32'h00,32'h04,1'b0};
    vecs[2]  = '{1'b0,1'b0,32'h00,32'h0,1'b0, 1'b1,32'h08,1'b1,32'h04,32'h08,1'b0};
    vecs[3]  = '{1'b1,1'b0,32'h00,32'h0,1'b0, 1'b1,32'h0C,1'b1,32'h08,32'h0C,1'b0};
    vecs[4]  = '{1'b1,1'b0,32'h00,32'h0,1'b0, 1'b0,32'h10,1'b1,32'h08,32'h0C,1'b0};
    vecs[5]  = '{1'b1,1'b0,32'h00,32'h0,1'b0, 1'b0,32'h10,1'b1,32'h08,32'h0C,1'b0};
    vecs[6]  = '{1'b0,1'b0,32'h00,32'h0,1'b0, 1'b0,32'h10,1'b1,32'h08,32'h0C,1'b0};
    vecs[7]  = '{1'b0,1'b0,32'h00,32'h0,1'b0, 1'b1,32'h10,1'b1,32'h0C,32'h10,1'b0};
    vecs[8]  = '{1'b0,1'b1,32'h10,32'h3,1'b0, 1'b1,32'h14,1'b1,32'h10,32'h14,1'b1};
    vecs[9]  = '{1'b0,1'b0,32'h00,32'h0,1'b0, 1'b1,32'h1C,1'b0,32'h00,32'h00,1'b0};
    vecs[10] = '{1'b1,1'b1,32'h40,32'h1,1'b0, 1'b1,32'h20,1'b1,32'h1C,32'h20,1'b0};
    vecs[11] = '{1'b0,1'b0,32'h00,32'h0,1'b0, 1'b0,32'h24,1'b1,32'h1C,32'h20,1'b0};
    vecs[12] = '{1'b0,1'b1,32'h10,32'h3,1'b1, 1'b1,32'h24,1'b1,32'h20,32'h24,1'b1};
    vecs[13] = '{1'b0,1'b0,32'h00,32'h0,1'b1, 1'b1,32'h24,1'b0,32'h00,32'h00,1'b0};
    vecs[14] = '{1'b0,1'b0,32'h00,32'h0,1'b0, 1'b1,32'h24,1'b0,32'h00,32'h00,1'b0};
    vecs[15] = '{1'b0,1'b0,32'h00,32'h0,1'b0, 1'b1,32'h1C,1'b0,32'h00,32'h00,1'b0};
    vecs[16] = '{1'b0,1'b0,32'h00,32'h0,1'b1, 1'b1,32'h20,1'b1,32'h1C,32'h20,1'b0};
    vecs[17] = '{1'b0,1'b0,32'h00,32'h0,1'b0, 1'b1,32'h20,1'b0,32'h00,32'h00,1'b0};
    vecs[18] = '{1'b1,1'b0,32'h00,32'h0,1'b1, 1'b1,32'h24,1'b1,32'h20,32'h24,1'b0};
    vecs[19] = '{1'b0,1'b0,32'h00,32'h0,1'b0, 1'b1,32'h24,1'b1,32'h20,32'h24,1'b0};
    vecs[20] = '{1'b0,1'b0,32'h00,32'h0,1'b0, 1'b1,32'h28,1'b1,32'h24,32'h28,1'b0};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst", instruction, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    rst = 1'b1;

    // streaming, freeze/skid, branch, freeze-vs-branch, drain, no-ack cases
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      freeze    = vecs[i].frz;
      br_taken  = vecs[i].br;
      id_pc     = vecs[i].idpc;
      br_offset = vecs[i].off;
      mem_stall = vecs[i].stall;
      #1;
      chk($sformatf("v%0d_flush", i), {31'h0, if_flush}, {31'h0, vecs[i].e_flush});
      chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].e_req});
      chk($sformatf("v%0d_valid", i), {31'h0, inst_valid}, {31'h0, vecs[i].e_valid});
      if (vecs[i].e_req)
        chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_inst", i), instruction, vecs[i].e_inst);
        chk($sformatf("v%0d_pc", i), pc_out, vecs[i].e_pc);
      end
    end

    @(negedge clk);
    freeze = 1'b0; br_taken = 1'b0; id_pc = 32'h0; br_offset = 32'h0;
    #1;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_flush", perf_flush_cnt, 32'd2);
    chk("perf_stall", perf_stall_cnt, 32'd7);
`endif
    chk("pre_rst_addr", imem_addr, 32'h2C);

    // reset while a request is outstanding without ack
    mem_stall = 1'b1;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_inst", instruction, 32'h0);
    chk("mid_rst_pc", pc_out, 32'h0);
    chk("mid_rst_valid", {31'h0, inst_valid}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("mid_rst_perf_flush", perf_flush_cnt, 32'h0);
    chk("mid_rst_perf_stall", perf_stall_cnt, 32'h0);
`endif

    // release into a memory that acks every second cycle
    @(negedge clk);
    mem_stall = 1'b0;
    lat = 1;
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      #1;
      chk($sformatf("lat%0d_req", j), {31'h0, imem_req}, 32'h1);
      chk($sformatf("lat%0d_addr_a", j), imem_addr, 32'(4 * j));
      chk($sformatf("lat%0d_valid_a", j), {31'h0, inst_valid}, (j > 0) ? 32'h1 : 32'h0);
      if (j > 0) begin
        chk($sformatf("lat%0d_inst", j), instruction, 32'(4 * (j - 1)));
        chk($sformatf("lat%0d_pc", j), pc_out, 32'(4 * j));
      end
      @(negedge clk);
      #1;
      chk($sformatf("lat%0d_addr_b", j), imem_addr, 32'(4 * j));
      chk($sformatf("lat%0d_valid_b", j), {31'h0, inst_valid}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
